// File: rtl/sequence_generator_io.sv
// sequence_generator_io: serial MSB-first pattern transmitter with repeats, idle gaps and done pulse.
// Optional even-parity bit per frame when SEQGEN_PARITY_EN is defined.
module sequence_generator_io #(
  parameter int PAT_W   = 4,
  parameter int GAP_CYC = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [7:0]       reps,
  output logic             o,
  output logic             o_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(PAT_W);
  localparam logic [3:0] GAP_LD = 4'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
  typedef enum logic [2:0] {
    IDLE,
    SEND,
`ifdef SEQGEN_PARITY_EN
    PAR,
`endif
    GAP,
    DONE
  } state_t;
  state_t state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, shift_q, shift_d, src;
  logic [CW-1:0] bit_q, bit_d;
  logic [7:0] rep_q, rep_d;
  logic [3:0] gap_q, gap_d;
  logic o_q, o_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic frame_end, reload;
  // A fresh start loads straight from the input; later frames replay the captured copy.
  assign src = (state_q == IDLE) ? pattern : pat_q;
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    o_d       = o_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    frame_end = 1'b0;
    reload    = 1'b0;
    case (state_q)
      IDLE: if (start && !abort) begin
        pat_d  = pattern;
        rep_d  = (reps == 8'd0) ? 8'd1 : reps;
        busy_d = 1'b1;
        reload = 1'b1;
      end
      SEND: if (bit_q != '0) begin
        o_d     = shift_q[PAT_W-1];
        shift_d = {shift_q[PAT_W-2:0], 1'b0};
        bit_d   = bit_q - 1'b1;
      end else begin
`ifdef SEQGEN_PARITY_EN
        state_d = PAR;
        o_d     = ^pat_q;
`else
        frame_end = 1'b1;
`endif
      end
`ifdef SEQGEN_PARITY_EN
      PAR: frame_end = 1'b1;
`endif
      GAP: if (gap_q == 4'd0) reload = 1'b1;
           else gap_d = gap_q - 4'd1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (frame_end) begin
      if (rep_q > 8'd1) begin
        rep_d = rep_q - 8'd1;
        if (GAP_CYC == 0) reload = 1'b1;
        else begin
          state_d = GAP;
          gap_d   = GAP_LD;
          o_d     = 1'b0;
          valid_d = 1'b0;
        end
      end else begin
        state_d = DONE;
        o_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
    if (reload) begin
      state_d = SEND;
      shift_d = {src[PAT_W-2:0], 1'b0};
      bit_d   = CW'(PAT_W - 1);
      o_d     = src[PAT_W-1];
      valid_d = 1'b1;
    end
    if (abort && busy_q) begin
      state_d = IDLE;
      o_d     = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      o_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign o       = o_q;
  assign o_valid = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: doc/sequence_generator_io.md
# sequence_generator_io

Serial pattern transmitter: the generating end of the single-bit serial sequence link. On a start request it captures a PAT_W-bit pattern and a repeat count, then shifts the pattern out MSB-first on `o`, one bit per clock. It inserts a configurable idle gap between repeats and pulses `done` at the end. It drives the `i` input of the downstream sequence detectors and serves as the stimulus source for detector benches.

## Interface
- `PAT_W`, default 4: pattern width in bits, minimum 2.
- `GAP_CYC`, default 0: idle cycles between consecutive repeats, 0..15.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low. 0 forces the reset state immediately, independent of `clock`.
- `start`  in  1  request to transmit; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of a transmission in progress.
- `pattern`  in  PAT_W  bits to send; captured on the accepting edge.
- `reps`  in  8  number of pattern repetitions; captured on the accepting edge. 0 is treated as 1.
- `o`  out  1  serial data bit.
- `o_valid`  out  1  `o` carries a pattern or parity bit this cycle.
- `busy`  out  1  a transmission is in progress.
- `done`  out  1  one-cycle pulse after the final bit of the final repeat.

## Operation
- All outputs are registered. While `reset`=0: state=IDLE, `o`=0, `o_valid`=0, `busy`=0, `done`=0, shift register=0, repeat counter=0, gap counter=0.
- **IDLE**
  - `start`=1 and `abort`=0 at an edge: load the shift register from `pattern` and the repeat counter from max(`reps`,1), then go to SEND.
  - That same edge drives `o`=`pattern[PAT_W-1]`, `o_valid`=1, `busy`=1.
  - `start` together with `abort` in IDLE: ignored.
- **SEND**
  - Each edge shifts the next lower bit onto `o`, MSB to LSB, PAT_W cycles with `o_valid`=1.
  - After the LSB cycle:
    - with parity enabled, go to PAR;
    - otherwise, if repeats remain, go to GAP (or straight back to SEND when `GAP_CYC`=0);
    - otherwise go to DONE.
  - Re-entering SEND reloads the captured pattern. A change on the `pattern` input mid-transmission has no effect.
- **PAR** (parity build only): one cycle, `o`=XOR of all captured pattern bits, `o_valid`=1. Then proceed to GAP, SEND or DONE using the same rule as SEND.
- **GAP**: `GAP_CYC` cycles with `o`=0, `o_valid`=0, `busy`=1. Then SEND.
- **DONE**: one cycle with `done`=1, `busy`=0, `o_valid`=0, `o`=0. Then IDLE.
  - `start` is ignored in DONE. A new start is accepted from IDLE only, so there is at least one idle cycle between transmissions.
- `start` while `busy`=1: ignored, no queuing.
- `abort`=1 at any edge with `busy`=1: next state IDLE, with `o`=0, `o_valid`=0, `busy`=0. `done` is not pulsed.
- Repeat counter: decrements at the end of each frame, where a frame is PAT_W bits plus the parity bit if present. It never wraps below 1.

## Timing
- Start latency: the first bit is on `o` in the cycle immediately after the edge that samples `start`.
- Frame length F = PAT_W, or PAT_W+1 in the parity build.
- Total `busy` cycles = N·F + (N−1)·`GAP_CYC`, where N = max(`reps`,1).
- `done` is asserted in the cycle after the last `o_valid` cycle.
- `reset` asserted mid-transmission: outputs clear asynchronously, with no `done` pulse. The first edge after `reset` deasserts samples IDLE normally.

## Configuration
- `SEQGEN_PARITY_EN` defined:
  - PAR state is present;
  - each frame is followed by one even-parity bit with `o_valid`=1;
  - F = PAT_W+1.
- `SEQGEN_PARITY_EN` not defined:
  - PAR state and parity logic are absent;
  - F = PAT_W.

## Test plan
- PAT_W=4, `GAP_CYC`=0, no parity; `pattern`=1011, `reps`=1, `start` pulse -> `o`=1,0,1,1 with `o_valid`=1 for 4 cycles; `done`=1 in cycle 5; `busy` high for exactly 4 cycles.
- `pattern`=0110, `reps`=3, `GAP_CYC`=2 -> 0110, 2 idle cycles, 0110, 2 idle cycles, 0110; `busy` 16 cycles; a single `done` pulse.
- `reps`=0 with `pattern`=1000 -> exactly one frame 1,0,0,0, then `done`.
- `reps`=5; `abort`=1 during bit 2 of repeat 2 -> `o_valid`=0 and `busy`=0 on the next cycle; no `done`; a fresh `start` two cycles later sends a full transmission.
- `reset` driven to 0 asynchronously between clock edges mid-frame -> all outputs 0 immediately; a second `start` asserted while `busy`=1 in a separate run has no effect on the output.
- `SEQGEN_PARITY_EN` defined, `pattern`=1011 -> `o`=1,0,1,1,1 over 5 `o_valid` cycles; `pattern`=1001 -> parity bit 0; `done` in cycle 6.
